// File: rtl/axil_ram_slave_pkg.sv
// Shared AXI4-lite configuration for axil_ram_slave: bus widths, response
// codes, FSM state encodings and the captured-write record.
package axil_ram_slave_pkg;

    localparam int AXI_ADDR_WIDTH   = 32;
    localparam int AXI_DATA_WIDTH   = 32;
    localparam int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int AXI_RESP_WIDTH   = 2;

    localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_DECERR = 2'b11;

    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;

    // Write address and data may arrive on different cycles; both are
    // parked here until the commit cycle.
    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0]   addr;
        logic [AXI_DATA_WIDTH-1:0]   data;
        logic [AXI_STROBE_WIDTH-1:0] strb;
    } wr_req_t;

endpackage

// File: rtl/axil_ram_slave_bram.sv
// bram_sdp_be: simple dual-port RAM, per-byte write enables, registered
// read port. Contents are never reset; only the read register clears.
module bram_sdp_be #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    // Registered read; holds its value until the next read.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/axil_ram_slave.sv
// axil_ram_slave: AXI4-lite memory slave with independent read and write
// FSMs over a bram_sdp_be. Optional macro AXIL_RAM_DECERR_EN turns
// out-of-range accesses into DECERR (write dropped, RDATA=0); without it
// the word index wraps modulo MEM_DEPTH_WORDS.
module axil_ram_slave
    import axil_ram_slave_pkg::*;
#(
    parameter int                        MEM_DEPTH_WORDS = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                  S_AXI_AWPROT,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_STROBE_WIDTH-1:0] S_AXI_WSTRB,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    output logic [AXI_RESP_WIDTH-1:0]   S_AXI_BRESP,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                  S_AXI_ARPROT,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [AXI_RESP_WIDTH-1:0]   S_AXI_RRESP
);

    localparam int IDX_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

    // Protection bits carry no meaning for a plain RAM.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    function automatic logic [IDX_W-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> 2;
        return IDX_W'(word % AXI_ADDR_WIDTH'(MEM_DEPTH_WORDS));
    endfunction

    rd_state_t  rd_state;
    logic       ar_ready, r_valid, r_err;
    wr_state_t  wr_state;
    logic       aw_ready, w_ready, aw_held, w_held, b_valid;
    logic [AXI_RESP_WIDTH-1:0] b_resp;
    wr_req_t    wr_req;

    logic       rd_in_range, wr_in_range;
    logic       rd_fire, wr_commit;
    logic [AXI_STROBE_WIDTH-1:0] wr_be;
    logic [AXI_DATA_WIDTH-1:0]   ram_q;

`ifdef AXIL_RAM_DECERR_EN
    function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> 2;
        return (addr >= BASE_ADDR) && (word < AXI_ADDR_WIDTH'(MEM_DEPTH_WORDS));
    endfunction
    assign rd_in_range = addr_ok(S_AXI_ARADDR);
    assign wr_in_range = addr_ok(wr_req.addr);
`else
    assign rd_in_range = 1'b1;
    assign wr_in_range = 1'b1;
`endif

    // ar_ready is only ever high in R_IDLE, so it alone qualifies the accept.
    assign rd_fire   = S_AXI_ARVALID && ar_ready;
    // Reset in the commit cycle must abort the write.
    assign wr_commit = (wr_state == W_IDLE) && aw_held && w_held && !RST;
    assign wr_be     = (wr_commit && wr_in_range) ? wr_req.strb : '0;

    bram_sdp_be #(
        .DEPTH  (MEM_DEPTH_WORDS),
        .DATA_W (AXI_DATA_WIDTH),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk     (CLK),
        .rst     (RST),
        .wr_be   (wr_be),
        .wr_addr (word_index(wr_req.addr)),
        .wr_data (wr_req.data),
        .rd_en   (rd_fire),
        .rd_addr (word_index(S_AXI_ARADDR)),
        .rd_data (ram_q)
    );

    // Read FSM: accept AR in R_IDLE, present data the next cycle, hold until RREADY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_state <= R_IDLE;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    ar_ready <= 1'b1;
                    if (rd_fire) begin
                        ar_ready <= 1'b0;
                        r_valid  <= 1'b1;
                        r_err    <= !rd_in_range;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        r_valid  <= 1'b0;
                        ar_ready <= 1'b1;
                        rd_state <= R_IDLE;
                    end
                end
            endcase
        end
    end

    // Write FSM: collect AW and W in any order, commit once both are held,
    // then hold the response until BREADY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_state <= W_IDLE;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_held && w_held) begin
                        wr_state <= W_RESP;
                        b_valid  <= 1'b1;
                        b_resp   <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                    end else begin
                        aw_ready <= !aw_held;
                        w_ready  <= !w_held;
                        if (S_AXI_AWVALID && aw_ready) begin
                            aw_held     <= 1'b1;
                            aw_ready    <= 1'b0;
                            wr_req.addr <= S_AXI_AWADDR;
                        end
                        if (S_AXI_WVALID && w_ready) begin
                            w_held      <= 1'b1;
                            w_ready     <= 1'b0;
                            wr_req.data <= S_AXI_WDATA;
                            wr_req.strb <= S_AXI_WSTRB;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        b_valid  <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        aw_ready <= 1'b1;
                        w_ready  <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
            endcase
        end
    end

    assign S_AXI_ARREADY = ar_ready;
    assign S_AXI_RVALID  = r_valid;
    assign S_AXI_RDATA   = r_err ? '0 : ram_q;
    assign S_AXI_RRESP   = r_err ? RESP_DECERR : RESP_OKAY;
    assign S_AXI_AWREADY = aw_ready;
    assign S_AXI_WREADY  = w_ready;
    assign S_AXI_BVALID  = b_valid;
    assign S_AXI_BRESP   = b_resp;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: randomized AXI4-lite traffic checked every cycle
// against a transaction-level memory model, plus literal directed checks.
module tb_axil_ram_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        AWVALID = 0, WVALID = 0, BREADY = 0, ARVALID = 0, RREADY = 0;
    logic [31:0] AWADDR = 0, WDATA = 0, ARADDR = 0;
    logic [3:0]  WSTRB = 0;
    logic [2:0]  AWPROT = 0, ARPROT = 0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    axil_ram_slave #(.MEM_DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST),
        .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY), .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT),
        .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY), .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB),
        .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY), .S_AXI_BRESP(BRESP),
        .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY), .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT),
        .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY), .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within 50 cycles at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_rng(input logic [31:0] a);
`ifdef AXIL_RAM_DECERR_EN
        return (a >= BASE) && (((a - BASE) >> 2) < DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % DEPTH);
    endfunction

    logic [31:0] mem_m [DEPTH];
    bit          rdy_ok = 0, r_pend = 0, aw_cap = 0, w_cap = 0, b_pend = 0;
    logic [31:0] r_data_e = 0, aw_a = 0, w_d = 0;
    logic [3:0]  w_s = 0;
    logic [1:0]  r_resp_e = 0, b_resp_e = 0;
    // events that will take effect at the coming rising edge
    bit          f_rst = 1, f_ar = 0, f_r = 0, f_aw = 0, f_w = 0, f_b = 0, f_commit = 0;
    logic [31:0] f_ar_a = 0, f_aw_a = 0, f_w_d = 0;
    logic [3:0]  f_w_s = 0;

    // Each falling edge: apply what happened at the last rising edge (a read
    // taken at the commit edge sees pre-write memory), compare, then predict
    // the handshakes of the next rising edge.
    always @(negedge CLK) begin
        if (f_rst) begin
            rdy_ok = 0; r_pend = 0; aw_cap = 0; w_cap = 0; b_pend = 0;
            r_data_e = 0; r_resp_e = 0; b_resp_e = 0;
        end else begin
            rdy_ok = 1;
            if (f_ar) begin
                r_pend   = 1;
                r_data_e = in_rng(f_ar_a) ? mem_m[widx(f_ar_a)] : 32'h0;
                r_resp_e = in_rng(f_ar_a) ? 2'b00 : 2'b11;
            end
            if (f_r) r_pend = 0;
            if (f_commit) begin
                if (in_rng(aw_a))
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) mem_m[widx(aw_a)][b*8 +: 8] = w_d[b*8 +: 8];
                b_resp_e = in_rng(aw_a) ? 2'b00 : 2'b11;
                b_pend   = 1;
            end
            if (f_b) begin b_pend = 0; aw_cap = 0; w_cap = 0; end
            if (f_aw) begin aw_cap = 1; aw_a = f_aw_a; end
            if (f_w)  begin w_cap = 1; w_d = f_w_d; w_s = f_w_s; end
        end

        chk("arready", ARREADY, rdy_ok && !r_pend);
        chk("awready", AWREADY, rdy_ok && !aw_cap);
        chk("wready",  WREADY,  rdy_ok && !w_cap);
        chk("rvalid",  RVALID,  r_pend);
        chk("bvalid",  BVALID,  b_pend);
        if (r_pend || !rdy_ok) begin
            chk("rdata", RDATA, r_data_e);
            chk("rresp", RRESP, r_resp_e);
        end
        if (b_pend || !rdy_ok) chk("bresp", BRESP, b_resp_e);

        f_rst    = RST;
        f_ar     = ARVALID && rdy_ok && !r_pend;   f_ar_a = ARADDR;
        f_r      = r_pend && RREADY;
        f_aw     = AWVALID && rdy_ok && !aw_cap;   f_aw_a = AWADDR;
        f_w      = WVALID && rdy_ok && !w_cap;     f_w_d = WDATA; f_w_s = WSTRB;
        f_b      = b_pend && BREADY;
        f_commit = rdy_ok && aw_cap && w_cap && !b_pend;
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd, input int bd, output logic [1:0] resp);
        resp = 2'bxx;
        fork
            begin : aw_ch
                int n;
                n = 0;
                repeat (awd) @(posedge CLK);
                #1 AWADDR = a; AWVALID = 1; AWPROT = 3'($urandom);
                @(negedge CLK);
                while (!AWREADY && n < 50) begin @(negedge CLK); n++; end
                if (!AWREADY) tmo("aw_handshake");
                @(posedge CLK); #1 AWVALID = 0;
            end
            begin : w_ch
                int n;
                n = 0;
                repeat (wd) @(posedge CLK);
                #1 WDATA = d; WSTRB = s; WVALID = 1;
                @(negedge CLK);
                while (!WREADY && n < 50) begin @(negedge CLK); n++; end
                if (!WREADY) tmo("w_handshake");
                @(posedge CLK); #1 WVALID = 0;
            end
        join
        begin : b_ch
            int n;
            n = 0;
            repeat (bd) @(posedge CLK);
            #1 BREADY = 1;
            @(negedge CLK);
            while (!BVALID && n < 50) begin @(negedge CLK); n++; end
            if (!BVALID) tmo("b_handshake");
            resp = BRESP;
            @(posedge CLK); #1 BREADY = 0;
        end
    endtask

    task automatic rd(input logic [31:0] a, input int rdly, output logic [31:0] d, output logic [1:0] resp);
        int n;
        n = 0;
        ARADDR = a; ARVALID = 1; ARPROT = 3'($urandom);
        @(negedge CLK);
        while (!ARREADY && n < 50) begin @(negedge CLK); n++; end
        if (!ARREADY) tmo("ar_handshake");
        @(posedge CLK); #1 ARVALID = 0;
        repeat (rdly) @(posedge CLK);
        #1 RREADY = 1;
        n = 0;
        @(negedge CLK);
        while (!RVALID && n < 50) begin @(negedge CLK); n++; end
        if (!RVALID) tmo("r_handshake");
        d = RDATA; resp = RRESP;
        @(posedge CLK); #1 RREADY = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2, br;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_arready", ARREADY, 0);
        chk("reset_rvalid", RVALID, 0);
        chk("reset_rdata", RDATA, 0);
        @(posedge CLK); #1 RST = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("post_reset_ready", {ARREADY, AWREADY, WREADY}, 3'b111);
        @(posedge CLK); #1;

        // fill every word so all later reads are predictable
        for (int i = 0; i < DEPTH; i++)
            wr(BASE + 32'(4 * i), $urandom, 4'hf, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), br);

        // same-cycle AW/W, then readback
        wr(32'h10, 32'hdeadbeef, 4'hf, 0, 0, 0, br);
        chk("wr10_bresp", br, 2'b00);
        rd(32'h10, 0, d, r);
        chk("rd10_data", d, 32'hdeadbeef);
        chk("rd10_resp", r, 2'b00);

        // W three cycles ahead of AW, partial strobe
        wr(32'h20, 32'hffffffff, 4'hf, 0, 0, 0, br);
        wr(32'h20, 32'h11223344, 4'h3, 3, 0, 1, br);
        rd(32'h20, 0, d, r);
        chk("rd20_partial", d, 32'hffff3344);

        // zero strobe leaves the word alone
        wr(32'h20, 32'h0, 4'h0, 0, 0, 0, br);
        chk("strb0_bresp", br, 2'b00);
        rd(32'h20, 0, d, r);
        chk("strb0_data", d, 32'hffff3344);

        // RREADY held low for five cycles
        rd(32'h10, 5, d, r);
        chk("rready_stall_data", d, 32'hdeadbeef);

        // read landing on the commit edge sees the old word
        wr(32'h30, 32'h55555555, 4'hf, 0, 0, 0, br);
        fork
            wr(32'h30, 32'haaaaaaaa, 4'hf, 0, 0, 0, br);
            begin @(posedge CLK); #1; rd(32'h30, 0, d, r); end
        join
        chk("rbw_old", d, 32'h55555555);
        rd(32'h30, 0, d, r);
        chk("rbw_new", d, 32'haaaaaaaa);

        // one word past the end
        wr(32'h0, 32'h0badf00d, 4'hf, 0, 0, 0, br);
        rd(BASE + 32'(4 * DEPTH), 0, d, r);
`ifdef AXIL_RAM_DECERR_EN
        chk("oor_resp", r, 2'b11);
        chk("oor_data", d, 32'h0);
`else
        chk("wrap_resp", r, 2'b00);
        chk("wrap_data", d, 32'h0badf00d);
`endif

        // reset after AW accepted, before W
        wr(32'h40, 32'h04040404, 4'hf, 0, 0, 0, br);
        AWADDR = 32'h40; AWVALID = 1;
        @(negedge CLK);
        chk("abort_aw_ready", AWREADY, 1);
        @(posedge CLK); #1 AWVALID = 0; RST = 1;
        @(posedge CLK);
        @(negedge CLK);
        chk("in_reset_ready", {ARREADY, AWREADY, WREADY, BVALID}, 4'b0000);
        @(posedge CLK); #1 RST = 0;
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_ready", {ARREADY, AWREADY, WREADY, BVALID}, 4'b1110);
        @(posedge CLK); #1;
        rd(32'h40, 0, d, r);
        chk("abort_retained", d, 32'h04040404);

        // randomized traffic, including wrap/out-of-range words and overlap
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a1, a2;
            int op;
            op = $urandom_range(0, 2);
            a1 = BASE + 32'(4 * $urandom_range(0, DEPTH + 3)) + 32'($urandom_range(0, 3));
            a2 = ($urandom_range(0, 1) == 1) ? a1 : BASE + 32'(4 * $urandom_range(0, DEPTH + 3));
            case (op)
                0: wr(a1, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br);
                1: rd(a1, $urandom_range(0, 3), d, r);
                default: fork
                    wr(a1, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), br);
                    begin repeat ($urandom_range(0, 3)) @(posedge CLK); #1; rd(a2, $urandom_range(0, 2), d2, r2); end
                join
            endcase
        end

        repeat (4) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
